// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port BRAM between CPU instruction and data ports
module mem_port_arbiter #(
    parameter int MEM_AW     = 12,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic              inst_ack,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_we,
    output logic              data_ack,
    output logic [31:0]       data_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              sel_inst_q, sel_inst_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [2:0]        lat_q, lat_d;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic              grant_inst;

    // Byte-offset bits and bits above the BRAM window are dropped (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:MEM_AW+2], inst_addr[1:0],
                                data_addr[31:MEM_AW+2], data_addr[1:0]};

    assign grant_inst = inst_req && (!data_req || (starve_q == SW'(STARVE_MAX)));

    always_comb begin
        state_d      = state_q;
        sel_inst_d   = sel_inst_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        starve_d     = starve_q;
        lat_d        = lat_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!inst_req) begin
                    starve_d = '0;
                end
                if (inst_req || data_req) begin
                    state_d    = S_ISSUE;
                    sel_inst_d = grant_inst;
                    if (grant_inst) begin
                        addr_d   = inst_addr[MEM_AW+1:2];
                        we_d     = 4'b0000;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        addr_d  = data_addr[MEM_AW+1:2];
                        we_d    = data_we;
                        wdata_d = data_wdata;
                        if (inst_req && (starve_q != SW'(STARVE_MAX))) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                lat_d   = '0;
                state_d = (we_q != 4'b0000) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                // Last wait cycle is exactly when the BRAM presents the read word.
                if (lat_q == 3'(MEM_LAT - 1)) begin
                    state_d = S_RESP;
                    if (sel_inst_q) begin
                        inst_rdata_d = mem_rdata;
                    end else begin
                        data_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            sel_inst_q   <= 1'b0;
            addr_q       <= '0;
            we_q         <= 4'b0000;
            wdata_q      <= '0;
            starve_q     <= '0;
            lat_q        <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_inst_q   <= sel_inst_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            starve_q     <= starve_d;
            lat_q        <= lat_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_en     = (state_q == S_ISSUE);
    assign mem_we     = mem_en ? we_q : 4'b0000;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign inst_ack   = (state_q == S_RESP) && sel_inst_q;
    assign data_ack   = (state_q == S_RESP) && !sel_inst_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (MEM_LAT 1 and 3 instances)
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    typedef struct {
        int          c;
        bit          is_inst;
        logic [31:0] rd;
    } ack_t;

    typedef struct {
        bit          inst;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [11:0] exp_maddr;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   gen = 1;
    int   total = 0;
    int   bad = 0;

    logic        i1_req = 0, d1_req = 0, i3_req = 0, d3_req = 0;
    logic [31:0] i1_addr = 0, d1_addr = 0, d1_wdata = 0, i3_addr = 0, d3_addr = 0, d3_wdata = 0;
    logic [3:0]  d1_we = 0, d3_we = 0;
    logic        ia1, da1, men1, ia3, da3, men3;
    logic [31:0] ird1, drd1, mwd1, ird3, drd3, mwd3;
    logic [3:0]  mwe1, mwe3;
    logic [11:0] maddr1, maddr3;
    logic [31:0] mrd1 = 0, mrd3 = 0, p3a = 0, p3b = 0;

    logic [31:0] bram1 [0:4095];
    logic [31:0] bram3 [0:4095];
    int          wg1 [0:4095];
    int          wg3 [0:4095];
    logic [31:0] refm [0:4095];
    ack_t        log1[$];
    ack_t        log3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.MEM_AW(12), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
        .aclk(clk), .areset(rst),
        .inst_req(i1_req), .inst_addr(i1_addr), .inst_ack(ia1), .inst_rdata(ird1),
        .data_req(d1_req), .data_addr(d1_addr), .data_wdata(d1_wdata), .data_we(d1_we),
        .data_ack(da1), .data_rdata(drd1),
        .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    mem_port_arbiter #(.MEM_AW(12), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
        .aclk(clk), .areset(rst),
        .inst_req(i3_req), .inst_addr(i3_addr), .inst_ack(ia3), .inst_rdata(ird3),
        .data_req(d3_req), .data_addr(d3_addr), .data_wdata(d3_wdata), .data_we(d3_we),
        .data_ack(da3), .data_rdata(drd3),
        .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwd3), .mem_rdata(mrd3)
    );

    function automatic logic [31:0] init_val(input int w);
        return 32'h5A00_0000 ^ (32'(w) * 32'h0001_0203) ^ (32'(gen) << 20);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd1(input logic [11:0] w);
        return (wg1[w] == gen) ? bram1[w] : init_val(int'(w));
    endfunction

    function automatic logic [31:0] rd3(input logic [11:0] w);
        return (wg3[w] == gen) ? bram3[w] : init_val(int'(w));
    endfunction

    // BRAM models: read word appears exactly MEM_LAT cycles after mem_en, zero otherwise.
    always @(posedge clk) begin
        mrd1 <= men1 ? rd1(maddr1) : 32'h0;
        if (men1 && mwe1 != 4'b0) begin
            bram1[maddr1] <= merge(rd1(maddr1), mwd1, mwe1);
            wg1[maddr1]   <= gen;
        end
    end

    always @(posedge clk) begin
        p3a  <= men3 ? rd3(maddr3) : 32'h0;
        p3b  <= p3a;
        mrd3 <= p3b;
        if (men3 && mwe3 != 4'b0) begin
            bram3[maddr3] <= merge(rd3(maddr3), mwd3, mwe3);
            wg3[maddr3]   <= gen;
        end
    end

    always @(negedge clk) begin
        if (ia1) log1.push_back('{c: cyc, is_inst: 1'b1, rd: ird1});
        if (da1) log1.push_back('{c: cyc, is_inst: 1'b0, rd: drd1});
        if (ia3) log3.push_back('{c: cyc, is_inst: 1'b1, rd: ird3});
        if (da3) log3.push_back('{c: cyc, is_inst: 1'b0, rd: drd3});
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run1(input int n, input bit hold_d);
        bit ai, ad;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ai = ia1;
            ad = da1;
            @(posedge clk);
            #1;
            if (ai) i1_req = 0;
            if (ad && !hold_d) d1_req = 0;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit seen;
        logic [11:0] ma;
        logic [3:0]  mw;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        if (v.inst) begin
            i1_req = 1; i1_addr = v.addr;
        end else begin
            d1_req = 1; d1_addr = v.addr; d1_we = v.we; d1_wdata = v.wdata;
        end
        lat = -1; seen = 0; ma = 0; mw = 0; rd = 0;
        for (int k = 0; k < 12 && lat < 0; k++) begin
            @(negedge clk);
            if (men1 && !seen) begin
                seen = 1; ma = maddr1; mw = mwe1;
            end
            if (v.inst ? ia1 : da1) begin
                lat = k; rd = v.inst ? ird1 : drd1;
            end
        end
        @(posedge clk);
        #1;
        i1_req = 0; d1_req = 0;
        check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("vec%0d_mem_addr", idx), 32'(ma), 32'(v.exp_maddr));
        check($sformatf("vec%0d_mem_we", idx), 32'(mw), v.inst ? 32'h0 : 32'(v.we));
        if (v.we == 4'b0) check($sformatf("vec%0d_rdata", idx), rd, v.exp_rd);
    endtask

    vec_t vt[8];

    initial begin
        int t0, n0, got;
        bit a;
        logic [31:0] iv2, ivf;
        int exp_off[6] = '{2, 5, 8, 11, 15, 18};
        bit exp_i[6]   = '{0, 0, 0, 0, 1, 0};

        iv2 = init_val(2);
        ivf = init_val(12'hFFF);
        vt[0] = '{1'b0, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 12'h004, 2, 32'h0};
        vt[1] = '{1'b1, 32'h0000_0010, 4'h0,    32'h0,         12'h004, 3, 32'hDEAD_BEEF};
        vt[2] = '{1'b0, 32'h0000_0008, 4'b0011, 32'h0000_1234, 12'h002, 2, 32'h0};
        vt[3] = '{1'b0, 32'h0000_0008, 4'h0,    32'h0,         12'h002, 3, {iv2[31:16], 16'h1234}};
        vt[4] = '{1'b1, 32'hFFFF_C013, 4'h0,    32'h0,         12'h004, 3, 32'hDEAD_BEEF};
        vt[5] = '{1'b0, 32'h0000_3FFC, 4'b1000, 32'h7700_0000, 12'hFFF, 2, 32'h0};
        vt[6] = '{1'b1, 32'h0000_3FFC, 4'h0,    32'h0,         12'hFFF, 3, {8'h77, ivf[23:0]}};
        vt[7] = '{1'b0, 32'h0000_4011, 4'h0,    32'h0,         12'h004, 3, 32'hDEAD_BEEF};

        // reset values
        #2;
        check("rst_inst_ack", 32'(ia1), 0);
        check("rst_data_ack", 32'(da1), 0);
        check("rst_mem_en", 32'(men1), 0);
        check("rst_mem_we", 32'(mwe1), 0);
        check("rst_mem_addr", 32'(maddr1), 0);
        check("rst_mem_wdata", mwd1, 0);
        check("rst_inst_rdata", ird1, 0);
        check("rst_data_rdata", drd1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // reset during ISSUE: mem_en drops at once, no ack follows
        n0 = log1.size();
        @(posedge clk); #1;
        i1_req = 1; i1_addr = 32'h10;
        @(posedge clk); #1;
        check("issue_mem_en", 32'(men1), 1);
        rst = 1;
        #1;
        check("rst_issue_mem_en", 32'(men1), 0);
        i1_req = 0;
        #1;
        rst = 0;
        repeat (6) @(posedge clk);
        check("rst_issue_no_ack", 32'(log1.size()), 32'(n0));

        // reset mid-WAIT on MEM_LAT=3, then normal service and back-to-back reads
        n0 = log3.size();
        @(posedge clk); #1;
        i3_req = 1; i3_addr = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("rst_wait_mem_en", 32'(men3), 0);
        check("rst_wait_inst_ack", 32'(ia3), 0);
        i3_req = 0;
        #1;
        rst = 0;
        repeat (8) @(posedge clk);
        check("rst_wait_no_ack", 32'(log3.size()), 32'(n0));
        #1;
        t0 = cyc; i3_req = 1; i3_addr = 32'h10; got = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            a = ia3;
            @(posedge clk);
            #1;
            if (a) begin
                got++;
                if (got == 1) i3_addr = 32'h20;
                else i3_req = 0;
            end
        end
        check("lat3_ack_count", 32'(log3.size()), 32'(n0 + 2));
        if (log3.size() >= n0 + 2) begin
            check("lat3_first_cycle", 32'(log3[n0].c - t0), 5);
            check("lat3_first_rdata", log3[n0].rd, init_val(4));
            check("lat3_spacing", 32'(log3[n0+1].c - log3[n0].c), 6);
            check("lat3_second_rdata", log3[n0+1].rd, init_val(8));
        end

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // simultaneous requests: data first, inst after data completes
        n0 = log1.size();
        @(posedge clk); #1;
        t0 = cyc;
        i1_req = 1; i1_addr = 32'h10;
        d1_req = 1; d1_addr = 32'h20; d1_we = 4'hF; d1_wdata = 32'hCAFE_F00D;
        run1(10, 0);
        check("simul_ack_count", 32'(log1.size()), 32'(n0 + 2));
        if (log1.size() >= n0 + 2) begin
            check("simul_first_is_data", 32'(log1[n0].is_inst), 0);
            check("simul_data_cycle", 32'(log1[n0].c - t0), 2);
            check("simul_second_is_inst", 32'(log1[n0+1].is_inst), 1);
            check("simul_inst_cycle", 32'(log1[n0+1].c - t0), 6);
            check("simul_inst_rdata", log1[n0+1].rd, 32'hDEAD_BEEF);
        end

        // starvation: data held continuously, inst waiting
        n0 = log1.size();
        @(posedge clk); #1;
        t0 = cyc;
        i1_req = 1; i1_addr = 32'h10;
        d1_req = 1; d1_addr = 32'h40; d1_we = 4'hF; d1_wdata = 32'h0BAD_F00D;
        run1(20, 1);
        run1(6, 0);
        check("starve_ack_count_min", 32'(log1.size() >= n0 + 6), 1);
        if (log1.size() >= n0 + 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("starve_ack%0d_port", k), 32'(log1[n0+k].is_inst), 32'(exp_i[k]));
                check($sformatf("starve_ack%0d_cycle", k), 32'(log1[n0+k].c - t0), 32'(exp_off[k]));
            end
        end

        // randomized traffic against a transaction-timeline reference model
        begin
            bit ip, dp, pi, pd, cur_i, first;
            logic [31:0] ia, da, dwd, exp_rd;
            logic [3:0] dwe, cur_we;
            int t, idle_at, issue_at, ack_at, starve, w, cur_w;
            gen++;
            for (int i = 0; i < 4096; i++) refm[i] = init_val(i);
            @(posedge clk); #1;
            i1_req = 0; d1_req = 0;
            rst = 1;
            #1;
            rst = 0;
            ip = 0; dp = 0; pi = 0; pd = 0; first = 1; cur_i = 0;
            ia = 0; da = 0; dwd = 0; dwe = 0; cur_we = 0; exp_rd = 0;
            idle_at = 0; issue_at = -1; ack_at = -1; starve = 0; cur_w = 0;
            for (int n = 0; n < 400; n++) begin
                @(posedge clk);
                #1;
                t = cyc;
                if (!ip || pi) begin
                    ip = ($urandom_range(0, 2) != 0);
                    ia = ($urandom & 32'hF000_003C) | ($urandom & 32'h3);
                end
                if (!dp || pd) begin
                    dp  = ($urandom_range(0, 2) != 0);
                    da  = ($urandom & 32'hF000_003C) | ($urandom & 32'h3);
                    dwd = $urandom;
                    dwe = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                end
                i1_req = ip; i1_addr = ia;
                d1_req = dp; d1_addr = da; d1_wdata = dwd; d1_we = dwe;
                if (first) begin
                    idle_at = t; first = 0;
                end
                if (t == idle_at) begin
                    if (!ip) starve = 0;
                    if (ip || dp) begin
                        cur_i = ip && (!dp || starve == SMAX);
                        if (cur_i) starve = 0;
                        else if (ip && starve < SMAX) starve++;
                        w = int'(((cur_i ? ia : da) >> 2) % 4096);
                        cur_w = w;
                        cur_we = cur_i ? 4'h0 : dwe;
                        exp_rd = refm[w];
                        if (cur_we != 0) refm[w] = merge(refm[w], dwd, cur_we);
                        issue_at = t + 1;
                        ack_at = t + ((cur_we != 0) ? 2 : 3);
                        idle_at = ack_at + 1;
                    end else begin
                        idle_at = t + 1;
                    end
                end
                @(negedge clk);
                check("rnd_inst_ack", 32'(ia1), 32'(t == ack_at && cur_i));
                check("rnd_data_ack", 32'(da1), 32'(t == ack_at && !cur_i));
                check("rnd_mem_en", 32'(men1), 32'(t == issue_at));
                if (t == issue_at) begin
                    check("rnd_mem_addr", 32'(maddr1), 32'(cur_w));
                    check("rnd_mem_we", 32'(mwe1), 32'(cur_we));
                end
                if (t == ack_at && cur_we == 0)
                    check("rnd_rdata", cur_i ? ird1 : drd1, exp_rd);
                pi = (t == ack_at) && cur_i;
                pd = (t == ack_at) && !cur_i;
            end
            @(posedge clk); #1;
            i1_req = 0; d1_req = 0;
            repeat (6) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
